// File: rtl/idu_decode_queue_pkg.sv
// Shared decode constants for the IDU decode queue: field widths, instruction numbers, opcodes.
// The instruction numbering is shared with downstream EXU tables; append only, never renumber.
package idu_decode_queue_pkg;

    localparam int unsigned INST_NUM_WIDTH = 8;
    localparam int unsigned FUNCT7_WIDTH   = 7;
    localparam int unsigned FUNCT3_WIDTH   = 3;
    localparam int unsigned OPCODE_WIDTH   = 7;

    typedef logic [INST_NUM_WIDTH-1:0] inst_num_t;
    typedef logic [OPCODE_WIDTH-1:0]   opcode_t;
    typedef logic [FUNCT3_WIDTH-1:0]   funct3_t;
    typedef logic [FUNCT7_WIDTH-1:0]   funct7_t;

    localparam inst_num_t inst_inv    = 8'd0;
    localparam inst_num_t inst_lui    = 8'd1;
    localparam inst_num_t inst_auipc  = 8'd2;
    localparam inst_num_t inst_jal    = 8'd3;
    localparam inst_num_t inst_jalr   = 8'd4;
    localparam inst_num_t inst_beq    = 8'd5;
    localparam inst_num_t inst_bne    = 8'd6;
    localparam inst_num_t inst_blt    = 8'd7;
    localparam inst_num_t inst_bge    = 8'd8;
    localparam inst_num_t inst_bltu   = 8'd9;
    localparam inst_num_t inst_bgeu   = 8'd10;
    localparam inst_num_t inst_lb     = 8'd11;
    localparam inst_num_t inst_lh     = 8'd12;
    localparam inst_num_t inst_lw     = 8'd13;
    localparam inst_num_t inst_lbu    = 8'd14;
    localparam inst_num_t inst_lhu    = 8'd15;
    localparam inst_num_t inst_sb     = 8'd16;
    localparam inst_num_t inst_sh     = 8'd17;
    localparam inst_num_t inst_sw     = 8'd18;
    localparam inst_num_t inst_addi   = 8'd19;
    localparam inst_num_t inst_slti   = 8'd20;
    localparam inst_num_t inst_sltiu  = 8'd21;
    localparam inst_num_t inst_xori   = 8'd22;
    localparam inst_num_t inst_ori    = 8'd23;
    localparam inst_num_t inst_andi   = 8'd24;
    localparam inst_num_t inst_slli   = 8'd25;
    localparam inst_num_t inst_srli   = 8'd26;
    localparam inst_num_t inst_srai   = 8'd27;
    localparam inst_num_t inst_add    = 8'd28;
    localparam inst_num_t inst_sub    = 8'd29;
    localparam inst_num_t inst_sll    = 8'd30;
    localparam inst_num_t inst_slt    = 8'd31;
    localparam inst_num_t inst_sltu   = 8'd32;
    localparam inst_num_t inst_xor    = 8'd33;
    localparam inst_num_t inst_srl    = 8'd34;
    localparam inst_num_t inst_sra    = 8'd35;
    localparam inst_num_t inst_or     = 8'd36;
    localparam inst_num_t inst_and    = 8'd37;
    localparam inst_num_t inst_fence  = 8'd38;
    localparam inst_num_t inst_ecall  = 8'd39;
    localparam inst_num_t inst_ebreak = 8'd40;
    localparam inst_num_t inst_mul    = 8'd41;
    localparam inst_num_t inst_mulh   = 8'd42;
    localparam inst_num_t inst_mulhsu = 8'd43;
    localparam inst_num_t inst_mulhu  = 8'd44;
    localparam inst_num_t inst_div    = 8'd45;
    localparam inst_num_t inst_divu   = 8'd46;
    localparam inst_num_t inst_rem    = 8'd47;
    localparam inst_num_t inst_remu   = 8'd48;

    localparam opcode_t opc_lui      = 7'b0110111;
    localparam opcode_t opc_auipc    = 7'b0010111;
    localparam opcode_t opc_jal      = 7'b1101111;
    localparam opcode_t opc_jalr     = 7'b1100111;
    localparam opcode_t opc_branch   = 7'b1100011;
    localparam opcode_t opc_load     = 7'b0000011;
    localparam opcode_t opc_store    = 7'b0100011;
    localparam opcode_t opc_op_imm   = 7'b0010011;
    localparam opcode_t opc_op       = 7'b0110011;
    localparam opcode_t opc_misc_mem = 7'b0001111;
    localparam opcode_t opc_system   = 7'b1110011;

    localparam funct7_t f7_base   = 7'b0000000;
    localparam funct7_t f7_alt    = 7'b0100000;
    localparam funct7_t f7_muldiv = 7'b0000001;

    localparam logic [31:0] ecall_word  = 32'h0000_0073;
    localparam logic [31:0] ebreak_word = 32'h0010_0073;

endpackage

// File: rtl/idu_decode_comb.sv
// Combinational RV32I decoder: opcode-keyed tables refined by funct3/funct7, default inv.
// Define IDU_RV32M_EN to also decode the M extension (OP opcode, funct7 = 0000001).
module idu_decode_comb
    import idu_decode_queue_pkg::*;
(
    input  logic [31:0] inst,
    output inst_num_t   inst_num,
    output logic        illegal,
    output logic        ebreak
);

    opcode_t opcode;
    funct3_t funct3;
    funct7_t funct7;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    always_comb begin
        inst_num = inst_inv;
        unique case (opcode)
            opc_lui:   inst_num = inst_lui;
            opc_auipc: inst_num = inst_auipc;
            opc_jal:   inst_num = inst_jal;
            opc_jalr: begin
                if (funct3 == 3'b000) inst_num = inst_jalr;
            end
            opc_branch: begin
                unique case (funct3)
                    3'b000:  inst_num = inst_beq;
                    3'b001:  inst_num = inst_bne;
                    3'b100:  inst_num = inst_blt;
                    3'b101:  inst_num = inst_bge;
                    3'b110:  inst_num = inst_bltu;
                    3'b111:  inst_num = inst_bgeu;
                    default: inst_num = inst_inv;
                endcase
            end
            opc_load: begin
                unique case (funct3)
                    3'b000:  inst_num = inst_lb;
                    3'b001:  inst_num = inst_lh;
                    3'b010:  inst_num = inst_lw;
                    3'b100:  inst_num = inst_lbu;
                    3'b101:  inst_num = inst_lhu;
                    default: inst_num = inst_inv;
                endcase
            end
            opc_store: begin
                unique case (funct3)
                    3'b000:  inst_num = inst_sb;
                    3'b001:  inst_num = inst_sh;
                    3'b010:  inst_num = inst_sw;
                    default: inst_num = inst_inv;
                endcase
            end
            opc_op_imm: begin
                unique case (funct3)
                    3'b000:  inst_num = inst_addi;
                    3'b010:  inst_num = inst_slti;
                    3'b011:  inst_num = inst_sltiu;
                    3'b100:  inst_num = inst_xori;
                    3'b110:  inst_num = inst_ori;
                    3'b111:  inst_num = inst_andi;
                    3'b001:  inst_num = (funct7 == f7_base) ? inst_slli : inst_inv;
                    3'b101: begin
                        if (funct7 == f7_base)     inst_num = inst_srli;
                        else if (funct7 == f7_alt) inst_num = inst_srai;
                    end
                    default: inst_num = inst_inv;
                endcase
            end
            opc_op: begin
                if (funct7 == f7_base) begin
                    unique case (funct3)
                        3'b000:  inst_num = inst_add;
                        3'b001:  inst_num = inst_sll;
                        3'b010:  inst_num = inst_slt;
                        3'b011:  inst_num = inst_sltu;
                        3'b100:  inst_num = inst_xor;
                        3'b101:  inst_num = inst_srl;
                        3'b110:  inst_num = inst_or;
                        default: inst_num = inst_and;
                    endcase
                end else if (funct7 == f7_alt) begin
                    if (funct3 == 3'b000)      inst_num = inst_sub;
                    else if (funct3 == 3'b101) inst_num = inst_sra;
`ifdef IDU_RV32M_EN
                end else if (funct7 == f7_muldiv) begin
                    unique case (funct3)
                        3'b000:  inst_num = inst_mul;
                        3'b001:  inst_num = inst_mulh;
                        3'b010:  inst_num = inst_mulhsu;
                        3'b011:  inst_num = inst_mulhu;
                        3'b100:  inst_num = inst_div;
                        3'b101:  inst_num = inst_divu;
                        3'b110:  inst_num = inst_rem;
                        default: inst_num = inst_remu;
                    endcase
`else
                end else begin
                    inst_num = inst_inv;
`endif
                end
            end
            opc_misc_mem: begin
                if (funct3 == 3'b000) inst_num = inst_fence;
            end
            // SYSTEM needs an exact word match; CSR accesses are not supported here.
            opc_system: begin
                if (inst == ecall_word)       inst_num = inst_ecall;
                else if (inst == ebreak_word) inst_num = inst_ebreak;
            end
            default: inst_num = inst_inv;
        endcase
    end

    assign illegal = (inst_num == inst_inv);
    assign ebreak  = (inst_num == inst_ebreak);

endmodule

// File: rtl/idu_decode_queue.sv
// Decode stage with a DEPTH-entry FIFO between IFU and EXU; stops accepting after an ebreak
// until flushed. IDU_RV32M_EN enables M-extension decode in idu_decode_comb.
module idu_decode_queue #(
    parameter int unsigned ISA_WIDTH      = 32,
    parameter int unsigned INST_NUM_WIDTH = 8,
    parameter int unsigned DEPTH          = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ISA_WIDTH-1:0]      in_inst,
    input  logic [ISA_WIDTH-1:0]      in_pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [INST_NUM_WIDTH-1:0] out_inst_num,
    output logic [ISA_WIDTH-1:0]      out_pc,
    output logic                      out_illegal,
    output logic                      out_ebreak,
    output logic [$clog2(DEPTH):0]    count
);
    import idu_decode_queue_pkg::*;

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [0:0] StRun  = 1'b0;
    localparam logic [0:0] StHalt = 1'b1;

    inst_num_t dec_num;
    logic      dec_illegal;
    logic      dec_ebreak;

    idu_decode_comb u_decode (
        .inst     (in_inst[31:0]),
        .inst_num (dec_num),
        .illegal  (dec_illegal),
        .ebreak   (dec_ebreak)
    );

    logic [INST_NUM_WIDTH-1:0] mem_num_q     [DEPTH];
    logic [ISA_WIDTH-1:0]      mem_pc_q      [DEPTH];
    logic                      mem_illegal_q [DEPTH];
    logic                      mem_ebreak_q  [DEPTH];

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [0:0]       state_q, state_d;

    logic full, empty, push, pop;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    // Registered-only ready: a full FIFO refuses a push even when the head pops this cycle.
    assign in_ready  = ~full & (state_q == StRun);
    assign out_valid = ~empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        state_d = state_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            state_d = StRun;
        end else begin
            if (push) wptr_d = wptr_q + PTR_W'(1);
            if (pop)  rptr_d = rptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (push && dec_ebreak) state_d = StHalt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            state_q <= StRun;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_num_q[i]     <= '0;
                mem_pc_q[i]      <= '0;
                mem_illegal_q[i] <= 1'b0;
                mem_ebreak_q[i]  <= 1'b0;
            end
        end else if (push && !flush) begin
            mem_num_q[wptr_q]     <= INST_NUM_WIDTH'(dec_num);
            mem_pc_q[wptr_q]      <= in_pc;
            mem_illegal_q[wptr_q] <= dec_illegal;
            mem_ebreak_q[wptr_q]  <= dec_ebreak;
        end
    end

    assign out_inst_num = mem_num_q[rptr_q];
    assign out_pc       = mem_pc_q[rptr_q];
    assign out_illegal  = mem_illegal_q[rptr_q];
    assign out_ebreak   = mem_ebreak_q[rptr_q];
    assign count        = count_q;

endmodule

// File: tb/tb_idu_decode_queue.sv
// Scoreboard bench for idu_decode_queue: expected head entries are queued as pushes are offered.
module tb_idu_decode_queue;
    import idu_decode_queue_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [31:0]   in_inst = '0;
    logic [31:0]   in_pc = '0;
    logic          in_ready;
    logic          out_valid;
    logic [7:0]    out_inst_num;
    logic [31:0]   out_pc;
    logic          out_illegal;
    logic          out_ebreak;
    logic [CW-1:0] count;

    idu_decode_queue #(
        .ISA_WIDTH      (32),
        .INST_NUM_WIDTH (8),
        .DEPTH          (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_inst      (in_inst),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_inst_num (out_inst_num),
        .out_pc       (out_pc),
        .out_illegal  (out_illegal),
        .out_ebreak   (out_ebreak),
        .count        (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  num;
        logic [31:0] pc;
        logic        eb;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic [42:0] head_v;
    logic [42:0] exp_v;
    assign head_v = {out_valid, out_inst_num, out_pc, out_illegal, out_ebreak};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction; record an expected entry only if it will actually be accepted.
    task automatic offer(input logic [31:0] inst, input logic [31:0] pc, input logic [7:0] num);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        if (in_ready && !flush) sb.push_back('{num: num, pc: pc, eb: (num == inst_ebreak)});
    endtask

    function automatic logic [42:0] pop_exp();
        exp_t e;
        if (sb.size() == 0) return '1;
        e = sb.pop_front();
        return {1'b1, e.num, e.pc, (e.num == inst_inv), e.eb};
    endfunction

    task automatic test_reset();
        tick();
        tick();
        n_cmp++;
        if ({out_valid, in_ready, count} !== {1'b0, 1'b1, CW'(0)}) begin
            n_err++;
            $display("FAIL reset_flags: got v=%0b r=%0b c=%0d want v=0 r=1 c=0",
                     out_valid, in_ready, count);
        end
        n_cmp++;
        if ({out_inst_num, out_pc} !== 40'h0) begin
            n_err++;
            $display("FAIL reset_head: got num=%0d pc=%h want 0/0", out_inst_num, out_pc);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_sub();
        out_ready = 1'b1;
        offer(32'h4020_8033, 32'h8000_0000, inst_sub);
        tick();
        in_valid = 1'b0;
        exp_v = pop_exp();
        n_cmp++;
        if (head_v !== exp_v) begin
            n_err++;
            $display("FAIL sub_head: got %h want %h", head_v, exp_v);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL sub_drained: got out_valid=%0b want 0", out_valid);
        end
    endtask

    task automatic test_decode_stream();
        logic [31:0] insts [11] = '{32'h0020_D013, 32'h4020_D013, 32'h2020_D013, 32'h0020_81B3,
                                    32'h0050_0093, 32'h0001_2083, 32'h1234_50B7, 32'h0000_0073,
                                    32'h3000_1073, 32'h0020_0073, 32'h0420_8033};
        logic [7:0]  nums  [11] = '{inst_srli, inst_srai, inst_inv, inst_add,
                                    inst_addi, inst_lw, inst_lui, inst_ecall,
                                    inst_inv, inst_inv, inst_inv};
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            offer(insts[i], 32'h0000_1000 + 32'(4 * i), nums[i]);
            tick();
            exp_v = pop_exp();
            n_cmp++;
            if (head_v !== exp_v) begin
                n_err++;
                $display("FAIL stream_head[%0d]: got %h want %h", i, head_v, exp_v);
            end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (count !== CW'(0)) begin
            n_err++;
            $display("FAIL stream_count: got %0d want 0", count);
        end
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL full_ready_before[%0d]: got %0b want 1", i, in_ready);
            end
            offer(32'h0020_81B3, 32'h0000_2000 + 32'(4 * i), inst_add);
            tick();
        end
        in_valid = 1'b0;
        n_cmp++;
        if ({in_ready, count} !== {1'b0, CW'(DEPTH)}) begin
            n_err++;
            $display("FAIL full_state: got r=%0b c=%0d want r=0 c=%0d", in_ready, count, DEPTH);
        end
        offer(32'h4020_8033, 32'h0000_2F00, inst_sub);
        out_ready = 1'b1;
        exp_v = pop_exp();
        n_cmp++;
        if (head_v !== exp_v) begin
            n_err++;
            $display("FAIL full_pop_head: got %h want %h", head_v, exp_v);
        end
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (count !== CW'(DEPTH - 1)) begin
            n_err++;
            $display("FAIL full_pop_count: got %0d want %0d", count, DEPTH - 1);
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            exp_v = pop_exp();
            n_cmp++;
            if (head_v !== exp_v) begin
                n_err++;
                $display("FAIL full_drain[%0d]: got %h want %h", i, head_v, exp_v);
            end
            tick();
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL full_drained: got out_valid=%0b want 0", out_valid);
        end
    endtask

    task automatic test_ebreak_flush();
        out_ready = 1'b0;
        offer(32'h0010_0073, 32'h0000_3000, inst_ebreak);
        tick();
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL ebreak_ready: got %0b want 0", in_ready);
        end
        offer(32'h0020_81B3, 32'h0000_3004, inst_add);
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (count !== CW'(1)) begin
            n_err++;
            $display("FAIL ebreak_blocks_add: got count=%0d want 1", count);
        end
        out_ready = 1'b1;
        exp_v = pop_exp();
        n_cmp++;
        if (head_v !== exp_v) begin
            n_err++;
            $display("FAIL ebreak_head: got %h want %h", head_v, exp_v);
        end
        tick();
        n_cmp++;
        if ({count, in_ready} !== {CW'(0), 1'b0}) begin
            n_err++;
            $display("FAIL halt_after_drain: got c=%0d r=%0b want c=0 r=0", count, in_ready);
        end
        out_ready = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++;
        if ({count, in_ready, out_valid} !== {CW'(0), 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL flush_run: got c=%0d r=%0b v=%0b want c=0 r=1 v=0",
                     count, in_ready, out_valid);
        end
    endtask

    task automatic test_flush_discard();
        out_ready = 1'b0;
        offer(32'h0020_81B3, 32'h0000_5000, inst_add);
        tick();
        offer(32'h0020_81B3, 32'h0000_5004, inst_add);
        tick();
        n_cmp++;
        if (count !== CW'(2)) begin
            n_err++;
            $display("FAIL flush_pre_count: got %0d want 2", count);
        end
        flush = 1'b1;
        offer(32'h4020_8033, 32'h0000_5008, inst_sub);
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        sb.delete();
        n_cmp++;
        if ({count, out_valid} !== {CW'(0), 1'b0}) begin
            n_err++;
            $display("FAIL flush_discard: got c=%0d v=%0b want c=0 v=0", count, out_valid);
        end
        offer(32'h4020_D013, 32'h0000_500C, inst_srai);
        tick();
        in_valid = 1'b0;
        exp_v = pop_exp();
        n_cmp++;
        if (head_v !== exp_v) begin
            n_err++;
            $display("FAIL flush_then_push: got %h want %h", head_v, exp_v);
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_mul();
`ifdef IDU_RV32M_EN
        logic [7:0] want = inst_mul;
`else
        logic [7:0] want = inst_inv;
`endif
        out_ready = 1'b1;
        offer(32'h0220_81B3, 32'h0000_4000, want);
        tick();
        in_valid = 1'b0;
        exp_v = pop_exp();
        n_cmp++;
        if (head_v !== exp_v) begin
            n_err++;
            $display("FAIL mul_head: got %h want %h", head_v, exp_v);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        offer(32'h0020_81B3, 32'h0000_6000, inst_add);
        tick();
        offer(32'h0020_81B3, 32'h0000_6004, inst_add);
        tick();
        offer(32'h0020_81B3, 32'h0000_6008, inst_add);
        n_cmp++;
        if (count !== CW'(2)) begin
            n_err++;
            $display("FAIL rst_pre_count: got %0d want 2", count);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, count, in_ready} !== {1'b0, CW'(0), 1'b1}) begin
            n_err++;
            $display("FAIL rst_async: got v=%0b c=%0d r=%0b want v=0 c=0 r=1",
                     out_valid, count, in_ready);
        end
        sb.delete();
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_sub();
        test_decode_stream();
        test_full();
        test_ebreak_flush();
        test_flush_discard();
        test_mul();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
